// File: rtl/md_pad_responder.sv
// Mega Drive / Genesis pad emulator: answers the host TH select line with the
// 3- or 6-button pad data on six active-low pins.
module md_pad_responder #(
    parameter int unsigned SIX_BUTTON     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 18000
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        sel_in,
    input  logic [11:0] btn,
    output logic [5:0]  pad_out,
    output logic [1:0]  phase
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    logic            sel_meta_q;
    logic            sel_s_q;
    logic            sel_d_q;
    logic            fall;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_hit;
    logic [1:0]      phase_q, phase_d;
    logic            idle_q, idle_d;
    logic [5:0]      pad_q, pad_d;
    logic [3:0]      low_data;

    assign fall = sel_d_q & ~sel_s_q;

    // Timeout counter: saturates, fires once on the cycle it reaches the limit.
    always_comb begin
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
        if (!sel_s_q) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CntMax) begin
                timeout_hit = 1'b1;
            end
        end
    end

    // The first fall after idle only arms the sequence; later falls advance it.
    always_comb begin
        phase_d = phase_q;
        idle_d  = idle_q;
        if (SIX_BUTTON == 0) begin
            phase_d = 2'd0;
            idle_d  = 1'b1;
        end else if (fall) begin
            if (idle_q) begin
                idle_d = 1'b0;
            end else if (phase_q != 2'd3) begin
                phase_d = phase_q + 2'd1;
            end
        end else if (timeout_hit) begin
            phase_d = 2'd0;
            idle_d  = 1'b1;
        end
    end

    // Pin order {TR, TL, D3, D2, D1, D0}; btn is pressed-high, pins are active-low.
    always_comb begin
        low_data = {2'b00, ~btn[2], ~btn[3]};
        pad_d    = 6'b111111;
        if (sel_s_q) begin
            if (phase_q == 2'd3) begin
                pad_d = {~btn[5], ~btn[4], ~btn[8], ~btn[9], ~btn[10], ~btn[11]};
            end else begin
                pad_d = {~btn[5], ~btn[4], ~btn[0], ~btn[1], ~btn[2], ~btn[3]};
            end
        end else begin
            unique case (phase_q)
                2'd2:    low_data = 4'b0000;
                2'd3:    low_data = 4'b1111;
                default: low_data = {2'b00, ~btn[2], ~btn[3]};
            endcase
            pad_d = {~btn[7], ~btn[6], low_data};
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            sel_meta_q <= 1'b1;
            sel_s_q    <= 1'b1;
            sel_d_q    <= 1'b1;
            cnt_q      <= '0;
            phase_q    <= 2'd0;
            idle_q     <= 1'b1;
            pad_q      <= 6'b111111;
        end else begin
            sel_meta_q <= sel_in;
            sel_s_q    <= sel_meta_q;
            sel_d_q    <= sel_s_q;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            idle_q     <= idle_d;
            pad_q      <= pad_d;
        end
    end

    assign pad_out = pad_q;
    assign phase   = phase_q;

endmodule
